// File: rtl/logic_ops_pkg.sv
// Shared definitions for the logic-op scheduler: opcodes, FSM state encoding
// and the bitwise operation itself.
package logic_ops_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NAND    = 3'd2;
  localparam logic [2:0] OP_NOR     = 3'd3;
  localparam logic [2:0] OP_XOR     = 3'd4;
  localparam logic [2:0] OP_XNOR    = 3'd5;
  localparam logic [2:0] OP_NOT     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Widest operand the shared function handles; callers zero-extend their
  // operands and size-cast the result back to their own width. Because every
  // op is bitwise, the low bits are unaffected by the extension.
  localparam int LOGIC_W_MAX = 64;

  function automatic logic [LOGIC_W_MAX-1:0] logic_op(
    input logic [2:0]             op,
    input logic [LOGIC_W_MAX-1:0] a,
    input logic [LOGIC_W_MAX-1:0] b
  );
    logic [LOGIC_W_MAX-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_scheduler_arb.sv
// Round-robin arbiter: grants the first active requester found scanning
// upward from ptr, wrapping modulo N_REQ (N_REQ need not be a power of 2).
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  // Rotating priority scan; only the first hit from ptr wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/logic_op_scheduler.sv
// Time-shares one registered bitwise logic unit among N_REQ requesters with
// round-robin arbitration and a single id-tagged response channel.
//
// state  | meaning
// IDLE   | arbitrate; grant one valid requester and capture its op/operands
// EXEC   | evaluate the captured op into the response registers
// RESP   | present the response until rsp_ready; then advance ptr past id
module logic_op_scheduler
  import logic_ops_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   busy
);

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [2:0]       cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [ID_W-1:0]  cap_id;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] result;
  logic [ID_W-1:0]  ptr_next;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Ready is only offered while idle, so a grant is a single-cycle pulse.
  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign busy      = (state != S_IDLE);

  assign result   = WIDTH'(logic_op(cap_op, LOGIC_W_MAX'(cap_a), LOGIC_W_MAX'(cap_b)));
  assign ptr_next = (cap_id == ID_W'(N_REQ - 1)) ? '0 : cap_id + 1'b1;

  // Sequencer: capture on grant, register result, hold response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cap_op    <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            cap_op <= req_op[3*grant_idx +: 3];
            cap_a  <= req_a[WIDTH*grant_idx +: WIDTH];
            cap_b  <= req_b[WIDTH*grant_idx +: WIDTH];
            cap_id <= grant_idx;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= result;
          rsp_err   <= (cap_op == OP_ILLEGAL);
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= ptr_next;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Bench for logic_op_scheduler (N_REQ=4, WIDTH=8): directed scenarios plus
// randomized traffic checked against a transaction-level reference.
module tb_logic_op_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0;
  logic [W*N-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  logic_op_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~(a & b);
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      6: return ~a;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int exp_grant(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input int op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3] = 3'(op);
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_valid[i]     = 1'b1;
  endtask

  // Runs one transaction from an idle negedge; reports what the DUT did.
  task automatic run_txn(input bit drop, input int stall, output int gnt, output int lat,
                         output logic [1:0] id, output logic [7:0] data, output logic err,
                         output int unstable);
    int waitc;
    logic [N-1:0] rdy;
    gnt = -1; lat = 0; unstable = 0; waitc = 0;
    id = 'x; data = 'x; err = 'x;
    #1;
    while (req_ready == 0 && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    rdy = req_ready;
    if ($countones(rdy) == 1) begin
      for (int i = 0; i < N; i++) if (rdy[i]) gnt = i;
    end else if (rdy != 0) begin
      gnt = -2;
    end
    if (gnt < 0) return;
    @(posedge clk); @(negedge clk);
    lat = 1;
    if (drop) req_valid[gnt] = 1'b0;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk); lat++;
    end
    id = rsp_id; data = rsp_data; err = rsp_err;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_data !== data || rsp_err !== err ||
          req_ready !== '0 || busy !== 1'b1) unstable++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    m_ptr = (gnt + 1) % N;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    n_vec++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    m_ptr = 0;
  endtask

  task automatic test_single();
    int g, l, u; logic [1:0] id; logic [7:0] d; logic e;
    set_req(0, 4, 8'hF0, 8'h3C);
    run_txn(1, 0, g, l, id, d, e, u);
    n_vec++; if (g !== 0) begin n_err++; $display("FAIL single_grant got %0d want 0", g); end
    n_vec++; if (l !== 2) begin n_err++; $display("FAIL single_latency got %0d want 2", l); end
    n_vec++; if (id !== 2'd0) begin n_err++; $display("FAIL single_id got %0d want 0", id); end
    n_vec++; if (d !== 8'hCC) begin n_err++; $display("FAIL single_data got %h want cc", d); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL single_err got %b want 0", e); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_release got %b want 0", rsp_valid); end
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_tab [8] = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'h00};
    int g, l, u; logic [1:0] id; logic [7:0] d; logic e;
    for (int op = 0; op < 8; op++) begin
      set_req(2, op, 8'hA5, 8'h0F);
      run_txn(1, 0, g, l, id, d, e, u);
      n_vec++; if (g !== 2 || id !== 2'd2) begin n_err++; $display("FAIL allops_id op%0d got %0d/%0d want 2", op, g, id); end
      n_vec++; if (d !== exp_tab[op]) begin n_err++; $display("FAIL allops_data op%0d got %h want %h", op, d, exp_tab[op]); end
      n_vec++; if (e !== (op == 7)) begin n_err++; $display("FAIL allops_err op%0d got %b want %b", op, e, op == 7); end
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int g, l, u; logic [1:0] id; logic [7:0] d; logic e;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i, 8'(8'h11 * (i + 1)), 8'h3C);
    for (int t = 0; t < 5; t++) begin
      run_txn(0, 0, g, l, id, d, e, u);
      n_vec++; if (g !== order[t]) begin n_err++; $display("FAIL rr_grant t%0d got %0d want %0d", t, g, order[t]); end
      n_vec++; if (d !== ref_op(order[t], 8'(8'h11 * (order[t] + 1)), 8'h3C))
        begin n_err++; $display("FAIL rr_data t%0d got %h", t, d); end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int g, l, u; logic [1:0] id; logic [7:0] d; logic e;
    set_req(1, 1, 8'h81, 8'h42);
    req_valid[3] = 1'b1;
    run_txn(1, 5, g, l, id, d, e, u);
    req_valid = '0;
    n_vec++; if (u !== 0) begin n_err++; $display("FAIL bp_stable got %0d unstable cycles want 0", u); end
    n_vec++; if (g !== exp_grant(4'b1010, 0) || d !== ref_op(1, 8'h81, 8'h42))
      begin n_err++; $display("FAIL bp_result got id %0d data %h", g, d); end
    #1;
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL bp_release got valid %b busy %b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_reset_mid();
    int g, l, u, seen; logic [1:0] id; logic [7:0] d; logic e;
    set_req(1, 0, 8'hFF, 8'h0F);
    run_txn(1, 0, g, l, id, d, e, u);
    set_req(3, 4, 8'h12, 8'h34);
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rmid_grant got %b want 1000", req_ready); end
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_exec_busy got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; m_ptr = 0;
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL rmid_after got valid %b busy %b want 0 0", rsp_valid, busy); end
    rsp_ready = 1'b1; seen = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid === 1'b1) seen++; end
    rsp_ready = 1'b0;
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rmid_dropped got %0d responses want 0", seen); end
    for (int i = 0; i < N; i++) set_req(i, 6, 8'h0F, 8'h00);
    run_txn(1, 0, g, l, id, d, e, u);
    req_valid = '0;
    n_vec++; if (g !== 0) begin n_err++; $display("FAIL rmid_ptr got grant %0d want 0", g); end
  endtask

  task automatic test_skip_idle();
    int g, l, u; logic [1:0] id; logic [7:0] d; logic e;
    set_req(1, 2, 8'h33, 8'h55);
    run_txn(1, 0, g, l, id, d, e, u);
    set_req(1, 3, 8'h0C, 8'h30);
    set_req(3, 5, 8'hF0, 8'hFF);
    run_txn(1, 0, g, l, id, d, e, u);
    n_vec++; if (g !== 3 || d !== 8'hF0) begin n_err++; $display("FAIL skip_first got %0d/%h want 3/f0", g, d); end
    run_txn(1, 0, g, l, id, d, e, u);
    n_vec++; if (g !== 1 || d !== 8'hC3) begin n_err++; $display("FAIL skip_second got %0d/%h want 1/c3", g, d); end
    req_valid = '0;
  endtask

  task automatic test_random();
    int g, l, u, eg, eop; logic [1:0] id; logic [7:0] d, ea, eb; logic e;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      if (req_valid == '0)
        set_req(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      eg  = exp_grant(req_valid, m_ptr);
      eop = int'(req_op[3*eg +: 3]);
      ea  = req_a[8*eg +: 8];
      eb  = req_b[8*eg +: 8];
      run_txn(1, int'($urandom_range(0, 3)), g, l, id, d, e, u);
      n_vec++; if (g !== eg || id !== 2'(eg)) begin n_err++; $display("FAIL rand_grant t%0d got %0d want %0d", t, g, eg); end
      n_vec++; if (l !== 2) begin n_err++; $display("FAIL rand_latency t%0d got %0d want 2", t, l); end
      n_vec++; if (d !== ref_op(eop, ea, eb) || e !== (eop == 7))
        begin n_err++; $display("FAIL rand_data t%0d got %h/%b want %h/%b", t, d, e, ref_op(eop, ea, eb), eop == 7); end
      n_vec++; if (u !== 0) begin n_err++; $display("FAIL rand_stable t%0d got %0d", t, u); end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ops();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_skip_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
